serial_comparator_framed: RTL

Parametrised serial magnitude comparator for framed operand streams. Each beat carries DIGIT_W-bit digits of two operands. A frame ends on a beat flagged `in_last`. Per frame, the block can treat digits as MSB-first or LSB-first and the operands as signed or unsigned. It sits behind serial links or bit-serial datapaths and returns one registered less/equal/greater verdict per frame, plus a beat count and an overflow flag.

---
 rtl/serial_cmp_pkg.sv | 28 ++
 rtl/serial_digit_compare.sv | 31 +++
 rtl/serial_comparator_framed.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the framed serial magnitude comparator.
//   cmp_res_t      : one-hot verdict encoding {less, eq, greater}
//   MODE_*         : bit positions inside the per-frame mode register
//   cmp_verdict()  : maps running eq/less flags onto a one-hot verdict
package serial_cmp_pkg;

  typedef enum logic [2:0] {
    CMP_LESS    = 3'b100,
    CMP_EQ      = 3'b010,
    CMP_GREATER = 3'b001
  } cmp_res_t;

  localparam int MODE_MSB_FIRST = 0;
  localparam int MODE_SIGNED    = 1;
  localparam int MODE_W         = 2;

  // Equality wins over less; greater is whatever remains.
  function automatic cmp_res_t cmp_verdict(input logic eq, input logic less);
    cmp_res_t r;
    case ({eq, less})
      2'b10, 2'b11: r = CMP_EQ;
      2'b01:        r = CMP_LESS;
      default:      r = CMP_GREATER;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serial_digit_compare.sv
// Combinational unsigned compare of one digit of each operand.
//   a, b        : operand digits
//   invert_msb  : flip the top bit of both digits (sign digit of a
//                 two's-complement operand, turning it into offset binary)
//   dlt, deq    : a' < b' and a' == b' after the optional flip
module serial_digit_compare
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               invert_msb,
  output logic               dlt,
  output logic               deq
);

  logic [DIGIT_W-1:0] a_s;
  logic [DIGIT_W-1:0] b_s;

  // Sign-bit flip and unsigned comparison.
  always_comb begin
    a_s = a;
    b_s = b;
    a_s[DIGIT_W-1] = a[DIGIT_W-1] ^ invert_msb;
    b_s[DIGIT_W-1] = b[DIGIT_W-1] ^ invert_msb;
    dlt = (a_s < b_s);
    deq = (a_s == b_s);
  end

endmodule

// File: rtl/serial_comparator_framed.sv
// Framed serial magnitude comparator. One registered less/eq/greater
// verdict per frame, plus beat count (saturating) and overflow flag.
//   clk, rst                 : clock, async active-low reset
//   in_valid, in_last        : beat qualifier, final beat of frame
//   msb_first, signed_cmp    : frame mode, taken from the first beat
//   a, b                     : operand digits
//   busy                     : frame in progress (registered)
//   res_valid                : one-cycle strobe when results update
//   res_less/eq/greater      : one-hot verdict of the last completed frame
//   res_beats, res_overflow  : beat count (saturated) and overflow flag
module serial_comparator_framed
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W   = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic                             in_last,
  input  logic                             msb_first,
  input  logic                             signed_cmp,
  input  logic [DIGIT_W-1:0]               a,
  input  logic [DIGIT_W-1:0]               b,
  output logic                             busy,
  output logic                             res_valid,
  output logic                             res_less,
  output logic                             res_eq,
  output logic                             res_greater,
  output logic [$clog2(MAX_BEATS+1)-1:0]   res_beats,
  output logic                             res_overflow
);

  localparam int              CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  logic              busy_r;
  logic [MODE_W-1:0] mode_r;
  logic              eq_r;
  logic              less_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              ovf_r;

  logic              res_valid_r;
  logic [2:0]        res_r;
  logic [CNT_W-1:0]  res_beats_r;
  logic              res_ovf_r;

  logic              first_s;
  logic [MODE_W-1:0] mode_s;
  logic              invert_s;
  logic              dlt_s;
  logic              deq_s;
  logic              eq_base_s;
  logic              less_base_s;
  logic              eq_next_s;
  logic              less_next_s;
  logic              ovf_next_s;
  logic [CNT_W-1:0]  cnt_base_s;
  logic [CNT_W-1:0]  cnt_next_s;
  cmp_res_t          verdict_s;

  // Effective mode for this beat: live inputs on the first beat, frozen after.
  always_comb begin
    first_s = ~busy_r;
    if (first_s) begin
      mode_s                 = mode_r;
      mode_s[MODE_MSB_FIRST] = msb_first;
      mode_s[MODE_SIGNED]    = signed_cmp;
    end else begin
      mode_s = mode_r;
    end
    // The sign digit is the first beat MSB-first, the last beat LSB-first.
    if (mode_s[MODE_MSB_FIRST]) begin
      invert_s = mode_s[MODE_SIGNED] & first_s;
    end else begin
      invert_s = mode_s[MODE_SIGNED] & in_last;
    end
  end

  serial_digit_compare #(.DIGIT_W(DIGIT_W)) u_digit (
    .a          (a),
    .b          (b),
    .invert_msb (invert_s),
    .dlt        (dlt_s),
    .deq        (deq_s)
  );

  // Next running state; the first beat starts from a fresh eq=1/less=0/cnt=0.
  always_comb begin
    eq_base_s   = first_s ? 1'b1 : eq_r;
    less_base_s = first_s ? 1'b0 : less_r;
    cnt_base_s  = first_s ? {CNT_W{1'b0}} : cnt_r;
    if (mode_s[MODE_MSB_FIRST]) begin
      // First differing digit decides; later digits cannot change it.
      if (eq_base_s) begin
        eq_next_s   = deq_s;
        less_next_s = dlt_s;
      end else begin
        eq_next_s   = eq_base_s;
        less_next_s = less_base_s;
      end
    end else begin
      // Later digits are more significant and override earlier ones.
      eq_next_s   = eq_base_s & deq_s;
      less_next_s = dlt_s | (deq_s & less_base_s);
    end
    ovf_next_s = (first_s ? 1'b0 : ovf_r) | (cnt_base_s == CNT_MAX);
    if (cnt_base_s == CNT_MAX) begin
      cnt_next_s = CNT_MAX;
    end else begin
      cnt_next_s = cnt_base_s + CNT_W'(1);
    end
    verdict_s = cmp_verdict(eq_next_s, less_next_s);
  end

  // Running frame state; the last beat returns the block to frame-idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= 1'b0;
      mode_r <= {MODE_W{1'b0}};
      eq_r   <= 1'b0;
      less_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      ovf_r  <= 1'b0;
    end else if (in_valid) begin
      busy_r <= ~in_last;
      mode_r <= mode_s;
      eq_r   <= eq_next_s;
      less_r <= less_next_s;
      cnt_r  <= cnt_next_s;
      ovf_r  <= ovf_next_s;
    end
  end

  // Result registers: load on the last beat, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_r <= 1'b0;
      res_r       <= 3'b000;
      res_beats_r <= {CNT_W{1'b0}};
      res_ovf_r   <= 1'b0;
    end else begin
      res_valid_r <= in_valid & in_last;
      if (in_valid && in_last) begin
        res_r       <= verdict_s;
        res_beats_r <= cnt_next_s;
        res_ovf_r   <= ovf_next_s;
      end
    end
  end

  assign busy         = busy_r;
  assign res_valid    = res_valid_r;
  assign res_less     = res_r[2];
  assign res_eq       = res_r[1];
  assign res_greater  = res_r[0];
  assign res_beats    = res_beats_r;
  assign res_overflow = res_ovf_r;

endmodule
